// File: rtl/ksa_swap_pkg.sv
// ksa_swap_pkg: shared types and constants for the RC4 key-scheduling swap block.
//   - ksa_state_e : FSM state encoding
//   - MEM_SEL_*   : memory_sel encodings driven onto the shared memory bus
//   - S_SIZE      : number of S-RAM entries (one permutation byte each)
//   - kidx_width  : width of the i-mod-KEY_LEN counter for a given key length
package ksa_swap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_I   = 3'd1,
    ST_WAIT_I = 3'd2,
    ST_RD_J   = 3'd3,
    ST_WAIT_J = 3'd4,
    ST_WR_I   = 3'd5,
    ST_WR_J   = 3'd6,
    ST_DONE   = 3'd7
  } ksa_state_e;

  localparam logic [1:0] MEM_SEL_NONE = 2'b00;
  localparam logic [1:0] MEM_SEL_S    = 2'b01;

  localparam int         S_SIZE = 256;
  // Last value of i; the run ends after this iteration instead of wrapping.
  localparam logic [7:0] I_LAST = 8'(S_SIZE - 1);

  // A one-byte key still needs a 1-bit counter so the port is never zero-width.
  function automatic int kidx_width(input int key_len);
    return (key_len > 1) ? $clog2(key_len) : 1;
  endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// ksa_key_sel: selects key byte key[i mod KEY_LEN] from the packed secret key.
// Ports:
//   i_kidx       in  KIDX_W  key-byte index (0..KEY_LEN-1)
//   i_secret_key in  KEY_W   key, byte 0 in the most significant byte
//   o_key_byte   out 8       selected key byte (0 for unused index codes)
module ksa_key_sel
  import ksa_swap_pkg::*;
#(
  parameter int KEY_LEN = 3,
  parameter int KEY_W   = 8 * KEY_LEN,
  parameter int KIDX_W  = kidx_width(KEY_LEN)
) (
  input  logic [KIDX_W-1:0] i_kidx,
  input  logic [KEY_W-1:0]  i_secret_key,
  output logic [7:0]        o_key_byte
);

  // AND-OR mux over the key bytes; exactly one term is enabled for a legal index.
  always_comb begin
    o_key_byte = 8'h00;
    for (int b = 0; b < KEY_LEN; b++) begin
      o_key_byte = o_key_byte |
                   (i_secret_key[KEY_W-1-8*b -: 8] & {8{i_kidx == KIDX_W'(b)}});
    end
  end

endmodule

// File: rtl/ksa_swap.sv
// ksa_swap: RC4 key-scheduling swap over an S-RAM pre-loaded with S[k]=k.
// For i = 0..255: j = j + S[i] + key[i mod KEY_LEN]; swap S[i], S[j].
// Every bus output is registered and reflects the action of the current
// state (it is loaded on the edge that enters the state), so one iteration
// is RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J = 6 cycles.
// Ports:
//   clk             in  1      clock, rising edge
//   reset_n         in  1      asynchronous active-low reset
//   state_start     in  1      start pulse, honoured only in IDLE or DONE
//   secret_key      in  KEY_W  key, byte 0 in the most significant byte
//   mem_q           in  8      S-RAM read data, valid the cycle after the address
//   address         out 8      S-RAM address
//   data            out 8      S-RAM write data
//   wen             out 1      S-RAM write enable (WR_I / WR_J only)
//   memory_sel      out 2      MEM_SEL_S while busy, MEM_SEL_NONE otherwise
//   ksa_mem_handler out 1      high while this block owns the memory bus
//   finish          out 1      high in DONE until the next accepted start
module ksa_swap
  import ksa_swap_pkg::*;
#(
  parameter int KEY_LEN = 3,
  parameter int KEY_W   = 8 * KEY_LEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             state_start,
  input  logic [KEY_W-1:0] secret_key,
  input  logic [7:0]       mem_q,
  output logic [7:0]       address,
  output logic [7:0]       data,
  output logic             wen,
  output logic [1:0]       memory_sel,
  output logic             ksa_mem_handler,
  output logic             finish
);

  localparam int                KIDX_W    = kidx_width(KEY_LEN);
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_LEN - 1);

  ksa_state_e        r_state;
  ksa_state_e        w_state_next;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [7:0]        r_j_next;
  logic [7:0]        r_si;
  logic [KIDX_W-1:0] r_kidx;
  logic [7:0]        r_address;
  logic [7:0]        r_data;
  logic              r_wen;
  logic [1:0]        r_mem_sel;
  logic              r_handler;
  logic              r_finish;
  logic [7:0]        w_key_byte;
  logic [7:0]        w_j_sum;

  ksa_key_sel #(
    .KEY_LEN (KEY_LEN),
    .KEY_W   (KEY_W),
    .KIDX_W  (KIDX_W)
  ) u_key_sel (
    .i_kidx       (r_kidx),
    .i_secret_key (secret_key),
    .o_key_byte   (w_key_byte)
  );

  // New j from the current j, S[i] arriving on mem_q and the key byte; wraps mod 256.
  assign w_j_sum = r_j + mem_q + w_key_byte;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a start pulse is only looked at in IDLE or DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (state_start) begin
          w_state_next = ST_RD_I;
        end else begin
          w_state_next = r_state;
        end
      end
      ST_RD_I:   w_state_next = ST_WAIT_I;
      ST_WAIT_I: w_state_next = ST_RD_J;
      ST_RD_J:   w_state_next = ST_WAIT_J;
      ST_WAIT_J: w_state_next = ST_WR_I;
      ST_WR_I:   w_state_next = ST_WR_J;
      ST_WR_J: begin
        if (r_i == I_LAST) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RD_I;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered bus outputs, loaded with the action of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i       <= 8'h00;
      r_j       <= 8'h00;
      r_j_next  <= 8'h00;
      r_si      <= 8'h00;
      r_kidx    <= {KIDX_W{1'b0}};
      r_address <= 8'h00;
      r_data    <= 8'h00;
      r_wen     <= 1'b0;
      r_mem_sel <= MEM_SEL_NONE;
      r_handler <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (state_start) begin
            // Entering RD_I for i = 0: present address 0 for the read.
            r_i       <= 8'h00;
            r_j       <= 8'h00;
            r_kidx    <= {KIDX_W{1'b0}};
            r_address <= 8'h00;
            r_wen     <= 1'b0;
            r_mem_sel <= MEM_SEL_S;
            r_handler <= 1'b1;
            r_finish  <= 1'b0;
          end
        end
        ST_RD_I: begin
          r_wen <= 1'b0;
        end
        ST_WAIT_I: begin
          // S[i] is on mem_q now; entering RD_J, so drive the read of S[j_next].
          r_si      <= mem_q;
          r_j_next  <= w_j_sum;
          r_address <= w_j_sum;
          r_wen     <= 1'b0;
        end
        ST_RD_J: begin
          r_j <= r_j_next;
        end
        ST_WAIT_J: begin
          // S[j] is on mem_q now; the data register doubles as the sj latch
          // and is presented directly for the WR_I write of S[i] = sj.
          r_address <= r_i;
          r_data    <= mem_q;
          r_wen     <= 1'b1;
        end
        ST_WR_I: begin
          r_address <= r_j;
          r_data    <= r_si;
          r_wen     <= 1'b1;
        end
        ST_WR_J: begin
          r_wen <= 1'b0;
          if (r_i == I_LAST) begin
            r_finish  <= 1'b1;
            r_handler <= 1'b0;
            r_mem_sel <= MEM_SEL_NONE;
          end else begin
            r_i       <= r_i + 8'd1;
            r_address <= r_i + 8'd1;
            r_kidx    <= (r_kidx == KIDX_LAST) ? {KIDX_W{1'b0}} : r_kidx + KIDX_W'(1);
          end
        end
        default: begin
          r_wen     <= 1'b0;
          r_mem_sel <= MEM_SEL_NONE;
          r_handler <= 1'b0;
        end
      endcase
    end
  end

  assign address         = r_address;
  assign data            = r_data;
  assign wen             = r_wen;
  assign memory_sel      = r_mem_sel;
  assign ksa_mem_handler = r_handler;
  assign finish          = r_finish;

endmodule

// File: tb/tb_ksa_swap.sv
// tb_ksa_swap: directed bench for ksa_swap with a synchronous S-RAM model
// and an independent software KSA model for the final permutation.
module tb_ksa_swap;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        state_start = 1'b0;
  logic [23:0] secret_key = 24'h000000;
  logic [7:0]  mem_q = 8'h00;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wen;
  logic [1:0]  memory_sel;
  logic        ksa_mem_handler;
  logic        finish;

  logic        init_req = 1'b0;
  logic [7:0]  sram [256];
  logic [7:0]  model_s [256];
  logic [15:0] wq [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic [23:0] key;
    logic [7:0]  exp_wr0_data;
    logic [7:0]  exp_wr1_addr;
    int          glitch_at;
  } vec_t;

  vec_t vecs [6];

  ksa_swap dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .state_start     (state_start),
    .secret_key      (secret_key),
    .mem_q           (mem_q),
    .address         (address),
    .data            (data),
    .wen             (wen),
    .memory_sel      (memory_sel),
    .ksa_mem_handler (ksa_mem_handler),
    .finish          (finish)
  );

  always #5 clk = ~clk;

  // Synchronous S-RAM: one-cycle read latency, writes logged in order.
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) sram[k] <= 8'(k);
    end else if (wen) begin
      sram[address] <= data;
      wq.push_back({address, data});
    end
    mem_q <= sram[address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic init_sram();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  // Reference RC4 KSA for a 3-byte key, byte 0 in bits 23:16.
  task automatic model_ksa(input logic [23:0] key);
    logic [7:0] j;
    logic [7:0] kb;
    logic [7:0] t;
    for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j  = j + model_s[i] + kb;
      t          = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic compare_final(input string name, input logic [23:0] key);
    int diffs;
    model_ksa(key);
    diffs = 0;
    for (int k = 0; k < 256; k++) begin
      if (sram[k] !== model_s[k]) diffs++;
    end
    check(name, diffs, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_address"}, int'(address), 0);
    check({tag, "_data"}, int'(data), 0);
    check({tag, "_wen"}, int'(wen), 0);
    check({tag, "_memsel"}, int'(memory_sel), 0);
    check({tag, "_handler"}, int'(ksa_mem_handler), 0);
    check({tag, "_finish"}, int'(finish), 0);
  endtask

  // Pulse start for one cycle; afterwards we sit in the first RD_I cycle.
  task automatic pulse_start();
    state_start = 1'b1;
    tick();
    state_start = 1'b0;
    check("start_finish_low", int'(finish), 0);
    check("start_handler", int'(ksa_mem_handler), 1);
    check("start_memsel", int'(memory_sel), 1);
  endtask

  // Full run from a freshly initialised S-RAM; returns cycles from first RD_I to finish.
  task automatic run_full(input logic [23:0] key, input int glitch_at, output int cycles);
    int c;
    secret_key = key;
    init_sram();
    wq.delete();
    pulse_start();
    c = 1;
    while (finish !== 1'b1 && c < 3000) begin
      if (c == glitch_at) state_start = 1'b1;
      tick();
      state_start = 1'b0;
      c++;
    end
    cycles = c - 1;
  endtask

  initial begin
    int cyc;
    int wsz;

    vecs[0] = '{key: 24'h030000, exp_wr0_data: 8'h03, exp_wr1_addr: 8'h03, glitch_at: 0};
    vecs[1] = '{key: 24'h000000, exp_wr0_data: 8'h00, exp_wr1_addr: 8'h00, glitch_at: 0};
    vecs[2] = '{key: 24'h000249, exp_wr0_data: 8'h00, exp_wr1_addr: 8'h00, glitch_at: 0};
    vecs[3] = '{key: 24'hABCDEF, exp_wr0_data: 8'hAB, exp_wr1_addr: 8'hAB, glitch_at: 0};
    vecs[4] = '{key: 24'hFF0102, exp_wr0_data: 8'hFF, exp_wr1_addr: 8'hFF, glitch_at: 100};
    vecs[5] = '{key: 24'h000249, exp_wr0_data: 8'h00, exp_wr1_addr: 8'h00, glitch_at: 100};

    // Reset state.
    tick();
    tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Cycle-exact first iteration for key 030000 (cycle 0 = start pulse).
    secret_key = 24'h030000;
    init_sram();
    wq.delete();
    pulse_start();
    check("c1_address", int'(address), 0);
    check("c1_wen", int'(wen), 0);
    repeat (4) tick();
    check("c5_wen", int'(wen), 1);
    check("c5_address", int'(address), 0);
    check("c5_data", int'(data), 3);
    tick();
    check("c6_wen", int'(wen), 1);
    check("c6_address", int'(address), 3);
    check("c6_data", int'(data), 0);
    tick();
    check("c7_wen", int'(wen), 0);
    check("c7_address", int'(address), 1);
    cyc = 7;
    while (finish !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("c_finish_cycle", cyc, 1537);
    compare_final("c_final_S", 24'h030000);

    // Table of full runs (some with an ignored start pulse at cycle 100).
    for (int v = 0; v < 6; v++) begin
      run_full(vecs[v].key, vecs[v].glitch_at, cyc);
      check($sformatf("v%0d_cycles", v), cyc, 1536);
      check($sformatf("v%0d_nwrites", v), wq.size(), 512);
      check($sformatf("v%0d_wr0", v), int'(wq[0]), int'({8'h00, vecs[v].exp_wr0_data}));
      check($sformatf("v%0d_wr1", v), int'(wq[1]), int'({vecs[v].exp_wr1_addr, 8'h00}));
      compare_final($sformatf("v%0d_final_S", v), vecs[v].key);
      repeat (3) tick();
      check($sformatf("v%0d_finish_held", v), int'(finish), 1);
      check($sformatf("v%0d_done_wen", v), int'(wen), 0);
      check($sformatf("v%0d_done_memsel", v), int'(memory_sel), 0);
      check($sformatf("v%0d_done_handler", v), int'(ksa_mem_handler), 0);
    end

    // Zero key: iteration i=1 has i==j, so S[1]=1 is written twice.
    run_full(24'h000000, 0, cyc);
    check("zk_wr2", int'(wq[2]), int'({8'h01, 8'h01}));
    check("zk_wr3", int'(wq[3]), int'({8'h01, 8'h01}));

    // Reset during iteration 40 (cycles 241..246), then a clean full run.
    secret_key = 24'h000249;
    init_sram();
    wq.delete();
    pulse_start();
    repeat (242) tick();
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    wsz = wq.size();
    repeat (3) tick();
    check("midreset_no_writes", wq.size(), wsz);
    reset_n = 1'b1;
    tick();
    run_full(24'h000249, 0, cyc);
    check("post_reset_cycles", cyc, 1536);
    compare_final("post_reset_final_S", 24'h000249);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
